// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: state encoding and counter sizing shared by the PLL lock supervisor.
package pll_sup_pkg;
    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction
endpackage

// File: rtl/pll_lock_supervisor_sync_bit.sv
// sync_bit: STAGES-deep flop chain bringing one asynchronous bit into the clk domain.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: resets the PLL, qualifies its lock and gates the downstream reset.
// Define PLL_LOCK_LOSS_COUNT_EN to add the saturating lock-loss counter output.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int STABLE_CYCLES       = 1024,
    parameter int SYNC_STAGES         = 2,
    parameter int LOSS_CNT_W          = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_lock_i,
    input  logic       soft_reset_i,
    output logic       pll_reset_o,
    output logic       sys_rst_n_o,
    output logic       ready_o,
    output logic       timeout_o,
    output logic [1:0] state_o
`ifdef PLL_LOCK_LOSS_COUNT_EN
    ,
    output logic [LOSS_CNT_W-1:0] loss_count_o
`endif
);
    localparam int CW = cnt_w(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, STABLE_CYCLES);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pll_reset_q, pll_reset_d;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          ready_q, ready_d;
    logic          timeout_q, timeout_d;
    logic          lock_s;

    sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_lock_i),
        .q_o   (lock_s)
    );

    always_comb begin
        state_d   = state_q;
        timeout_d = 1'b0;
        if (soft_reset_i) begin
            state_d = PLL_RST;
        end else begin
            case (state_q)
                PLL_RST:
                    if (cnt_q == CW'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
                WAIT_LOCK:
                    if (lock_s) state_d = STABLE;
                    else if (cnt_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        state_d   = PLL_RST;
                        timeout_d = 1'b1;
                    end
                STABLE:
                    if (!lock_s) state_d = WAIT_LOCK;
                    else if (cnt_q == CW'(STABLE_CYCLES - 1)) state_d = RUN;
                default:
                    if (!lock_s) state_d = PLL_RST;
            endcase
        end
        // RUN has no terminal count, so the counter idles at zero there
        cnt_d       = (soft_reset_i || state_d != state_q || state_q == RUN) ? '0 : cnt_q + 1'b1;
        pll_reset_d = state_d == PLL_RST;
        sys_rst_n_d = state_d == RUN;
        ready_d     = state_d == RUN;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            timeout_q   <= timeout_d;
        end
    end

    assign pll_reset_o = pll_reset_q;
    assign sys_rst_n_o = sys_rst_n_q;
    assign ready_o     = ready_q;
    assign timeout_o   = timeout_q;
    assign state_o     = state_q;

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;

    always_comb loss_d = (state_q == RUN && !lock_s && !soft_reset_i && !(&loss_q)) ? loss_q + 1'b1 : loss_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) loss_q <= '0;
        else        loss_q <= loss_d;
    end

    assign loss_count_o = loss_q;
`endif
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed scenarios checked against a phase/duration model of the supervisor.
module tb_pll_lock_supervisor;
    localparam int PRC  = 4;
    localparam int TO   = 100;
    localparam int ST   = 8;
    localparam int SYNC = 2;
    localparam int LW   = 8;

    localparam int C_PLL_LOW = 0, C_SYS_HI = 1, C_TO = 2, C_SYS_LO = 3, C_ST2 = 4, C_READY = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pll_lock_i = 1'b0;
    logic       soft_reset_i = 1'b0;
    logic       pll_reset_o, sys_rst_n_o, ready_o, timeout_o;
    logic [1:0] state_o;
`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic [LW-1:0] loss_count_o;
`endif

    pll_lock_supervisor #(
        .PLL_RST_CYCLES      (PRC),
        .LOCK_TIMEOUT_CYCLES (TO),
        .STABLE_CYCLES       (ST),
        .SYNC_STAGES         (SYNC),
        .LOSS_CNT_W          (LW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_lock_i   (pll_lock_i),
        .soft_reset_i (soft_reset_i),
        .pll_reset_o  (pll_reset_o),
        .sys_rst_n_o  (sys_rst_n_o),
        .ready_o      (ready_o),
        .timeout_o    (timeout_o),
        .state_o      (state_o)
`ifdef PLL_LOCK_LOSS_COUNT_EN
        ,
        .loss_count_o (loss_count_o)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int seq[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase plus edges spent in it; lock is seen SYNC edges after it is sampled
    int m_ph, m_nph, m_dur, m_loss;
    bit m_l1, m_l2, m_ls, m_to;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ph = 0; m_dur = 0; m_l1 = 0; m_l2 = 0; m_to = 0; m_loss = 0;
        end else begin
            m_ls  = m_l2;
            m_l2  = m_l1;
            m_l1  = pll_lock_i;
            m_to  = 0;
            m_nph = m_ph;
            m_dur++;
            if (soft_reset_i) m_nph = 0;
            else if (m_ph == 0 && m_dur == PRC) m_nph = 1;
            else if (m_ph == 1 && m_ls) m_nph = 2;
            else if (m_ph == 1 && m_dur == TO) begin m_nph = 0; m_to = 1; end
            else if (m_ph == 2 && !m_ls) m_nph = 1;
            else if (m_ph == 2 && m_dur == ST) m_nph = 3;
            else if (m_ph == 3 && !m_ls) begin
                m_nph = 0;
                if (m_loss < (1 << LW) - 1) m_loss++;
            end
            if (m_nph != m_ph || soft_reset_i) m_dur = 0;
            m_ph = m_nph;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("state_o", int'(state_o), m_ph);
        chk("pll_reset_o", int'(pll_reset_o), int'(m_ph == 0));
        chk("sys_rst_n_o", int'(sys_rst_n_o), int'(m_ph == 3));
        chk("ready_o", int'(ready_o), int'(m_ph == 3));
        chk("timeout_o", int'(timeout_o), int'(m_to));
`ifdef PLL_LOCK_LOSS_COUNT_EN
        chk("loss_count_o", int'(loss_count_o), m_loss);
`endif
        if (seq.size() == 0 || seq[$] != int'(state_o)) seq.push_back(int'(state_o));
    end

    function automatic bit cond(input int c);
        case (c)
            C_PLL_LOW: return !pll_reset_o;
            C_SYS_HI:  return sys_rst_n_o;
            C_TO:      return timeout_o;
            C_SYS_LO:  return !sys_rst_n_o;
            C_ST2:     return state_o == 2'd2;
            default:   return ready_o;
        endcase
    endfunction

    task automatic count_until(input int c, input int max, input string name, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!cond(c) && n < max);
        if (!cond(c)) begin
            checks++;
            errors++;
            $display("FAIL %s: wait expired after %0d cycles", name, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seq.delete();
    endtask

    int n, n2;
    int exp1[4] = '{0, 1, 2, 3};
    int exp3[6] = '{0, 1, 2, 1, 2, 3};

    initial begin
        #1 rst_n = 1'b0;

        // 1: clean bring-up
        do_reset();
        count_until(C_PLL_LOW, 20, "t1 pll_reset width", n);
        chk("t1 pll_reset width", n, 4);
        repeat (10) @(negedge clk);
        pll_lock_i = 1'b1;
        count_until(C_SYS_HI, 50, "t1 release latency", n);
        chk("t1 release latency", n, SYNC + 1 + ST);
        chk("t1 ready", int'(ready_o), 1);
        @(negedge clk);
        chk("t1 seq len", seq.size(), 4);
        for (int i = 0; i < seq.size() && i < 4; i++) chk("t1 seq", seq[i], exp1[i]);

        // 2: lock never arrives
        pll_lock_i = 1'b0;
        do_reset();
        count_until(C_TO, 300, "t2 first timeout", n);
        chk("t2 first timeout", n, PRC + TO);
        count_until(C_PLL_LOW, 20, "t2 retry width", n);
        chk("t2 retry width", n, 4);
        count_until(C_TO, 300, "t2 second timeout", n2);
        chk("t2 period", n + n2, 104);
        chk("t2 sys_rst_n", int'(sys_rst_n_o), 0);

        // 3: one-cycle lock dropout while stabilising
        pll_lock_i = 1'b0;
        do_reset();
        count_until(C_PLL_LOW, 20, "t3 pll fall", n);
        @(negedge clk);
        pll_lock_i = 1'b1;
        repeat (5) @(negedge clk);
        pll_lock_i = 1'b0;
        @(negedge clk);
        pll_lock_i = 1'b1;
        count_until(C_SYS_HI, 50, "t3 release", n);
        chk("t3 release", n, SYNC + 1 + ST);
        @(negedge clk);
        chk("t3 seq len", seq.size(), 6);
        for (int i = 0; i < seq.size() && i < 6; i++) chk("t3 seq", seq[i], exp3[i]);

        // 4: lock lost in RUN
        @(negedge clk);
        pll_lock_i = 1'b0;
        count_until(C_SYS_LO, 20, "t4 drop latency", n);
        chk("t4 drop latency", n, SYNC + 1);
        chk("t4 state", int'(state_o), 0);
        chk("t4 pll_reset", int'(pll_reset_o), 1);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        chk("t4 loss", int'(loss_count_o), 1);
`endif

        // 5: soft reset in STABLE and in RUN
        @(negedge clk);
        pll_lock_i = 1'b1;
        count_until(C_ST2, 50, "t5 reach stable", n);
        @(negedge clk);
        soft_reset_i = 1'b1;
        @(posedge clk);
        #1;
        chk("t5 stable soft state", int'(state_o), 0);
        chk("t5 stable soft timeout", int'(timeout_o), 0);
        @(negedge clk);
        soft_reset_i = 1'b0;
        count_until(C_READY, 50, "t5 reach run", n);
        @(negedge clk);
        soft_reset_i = 1'b1;
        @(posedge clk);
        #1;
        chk("t5 run soft state", int'(state_o), 0);
        chk("t5 run soft sys_rst_n", int'(sys_rst_n_o), 0);
        chk("t5 run soft timeout", int'(timeout_o), 0);
`ifdef PLL_LOCK_LOSS_COUNT_EN
        chk("t5 loss unchanged", int'(loss_count_o), 1);
`endif
        @(negedge clk);
        soft_reset_i = 1'b0;

        // 6: asynchronous reset mid-WAIT_LOCK
        pll_lock_i = 1'b0;
        do_reset();
        count_until(C_PLL_LOW, 20, "t6 pll fall", n);
        repeat (5) @(negedge clk);
        chk("t6 in wait_lock", int'(state_o), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6 async state", int'(state_o), 0);
        chk("t6 async pll_reset", int'(pll_reset_o), 1);
        chk("t6 async sys_rst_n", int'(sys_rst_n_o), 0);
        chk("t6 async ready", int'(ready_o), 0);
        chk("t6 async timeout", int'(timeout_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef PLL_LOCK_LOSS_COUNT_EN
        pll_lock_i = 1'b1;
        for (int k = 0; k < 300; k++) begin
            count_until(C_READY, 100, "t6 reach run", n);
            @(negedge clk);
            pll_lock_i = 1'b0;
            @(negedge clk);
            pll_lock_i = 1'b1;
        end
        repeat (5) @(negedge clk);
        chk("t6 loss saturated", int'(loss_count_o), 255);
`endif
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
